// File: rtl/char_render_if.sv
// Signal bundle between the sync generator / text RAM / glyph ROM side and the
// character renderer. The renderer uses the slave modport; the environment drives through master.
interface char_render_if #(
  parameter int CHAR_W = 8
);
  logic [11:0]       H_count;
  logic [11:0]       V_count;
  logic              hsync;
  logic              vsync;
  logic              vid_active;
  logic [11:0]       txt_addr;
  logic [7:0]        txt_data;
  logic [11:0]       rom_addr;
  logic [CHAR_W-1:0] rom_data;
  logic [6:0]        cursor_col;
  logic [4:0]        cursor_row;
  logic              cursor_en;
  logic [11:0]       rgb;
  logic              hsync_out;
  logic              vsync_out;
  logic              active_out;

  modport slave (
    input  H_count, V_count, hsync, vsync, vid_active,
    input  txt_data, rom_data, cursor_col, cursor_row, cursor_en,
    output txt_addr, rom_addr, rgb, hsync_out, vsync_out, active_out
  );

  modport master (
    output H_count, V_count, hsync, vsync, vid_active,
    output txt_data, rom_data, cursor_col, cursor_row, cursor_en,
    input  txt_addr, rom_addr, rgb, hsync_out, vsync_out, active_out
  );
endinterface

// File: rtl/char_render.sv
// Text-mode pixel renderer: 4-stage pipeline from sync-generator counts to RGB444,
// fetching character codes and glyph rows from external 1-cycle RAM/ROM, with a blinking cursor.
module char_render #(
  parameter int          CHAR_W       = 8,
  parameter int          CHAR_H       = 16,
  parameter int          COLS         = 80,
  parameter int          ROWS         = 30,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000
) (
  input  logic         pix_clk,
  input  logic         rst,
  char_render_if.slave bus
);
  localparam int GC_W = $clog2(CHAR_W);
  localparam int GR_W = $clog2(CHAR_H);
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [GR_W-1:0] gRow;
    logic [GC_W-1:0] gCol;
    logic            hit;
    logic            hs;
    logic            vs;
    logic            act;
  } side_t;

  logic [11:0]     w_col;
  logic [11:0]     w_row;
  logic [11:0]     w_cellAddr;
  logic            w_hit;
  logic            w_vsRise;
  logic            w_pixBit;
  logic            w_inv;

  side_t           r_side0;
  side_t           r_side1;
  side_t           r_side2;
  logic [11:0]     r_txtAddr;
  logic [11:0]     r_rgb;
  logic            r_hsOut;
  logic            r_vsOut;
  logic            r_actOut;
  logic            r_vsPrev;
  logic            r_blink;
  logic [FC_W-1:0] r_frameCnt;

  // Cursor coordinates outside the text area must never match, even in blanking.
  always_comb begin
    w_col      = bus.H_count >> GC_W;
    w_row      = bus.V_count >> GR_W;
    w_cellAddr = w_row * 12'(COLS) + w_col;
    w_hit      = bus.cursor_en
                 && (w_col < 12'(COLS)) && (w_row < 12'(ROWS))
                 && (w_col == {5'd0, bus.cursor_col})
                 && (w_row == {7'd0, bus.cursor_row});
    w_vsRise   = bus.vsync & ~r_vsPrev;
    w_pixBit   = bus.rom_data[~r_side2.gCol];
    w_inv      = r_side2.hit & r_blink;
  end

  always_ff @(posedge pix_clk or negedge rst) begin
    if (!rst) begin
      r_txtAddr <= '0;
      r_side0   <= '0;
      r_side1   <= '0;
      r_side2   <= '0;
    end else begin
      r_txtAddr <= bus.vid_active ? w_cellAddr : 12'd0;
      r_side0   <= '{gRow: bus.V_count[GR_W-1:0], gCol: bus.H_count[GC_W-1:0],
                     hit: w_hit, hs: bus.hsync, vs: bus.vsync, act: bus.vid_active};
      r_side1   <= r_side0;
      r_side2   <= r_side1;
    end
  end

  // Stage 3: glyph bit from ROM, optionally inverted by the cursor, forced black in blanking.
  always_ff @(posedge pix_clk or negedge rst) begin
    if (!rst) begin
      r_rgb    <= '0;
      r_hsOut  <= 1'b0;
      r_vsOut  <= 1'b0;
      r_actOut <= 1'b0;
    end else begin
      r_rgb    <= !r_side2.act ? 12'h000 : ((w_pixBit ^ w_inv) ? FG_COLOR : BG_COLOR);
      r_hsOut  <= r_side2.hs;
      r_vsOut  <= r_side2.vs;
      r_actOut <= r_side2.act;
    end
  end

  // Blink phase flips once every BLINK_FRAMES vsync rising edges; it starts visible.
  always_ff @(posedge pix_clk or negedge rst) begin
    if (!rst) begin
      r_vsPrev   <= 1'b0;
      r_frameCnt <= '0;
      r_blink    <= 1'b1;
    end else begin
      r_vsPrev <= bus.vsync;
      if (w_vsRise) begin
        if (r_frameCnt == FC_W'(BLINK_FRAMES - 1)) begin
          r_frameCnt <= '0;
          r_blink    <= ~r_blink;
        end else begin
          r_frameCnt <= r_frameCnt + 1'b1;
        end
      end
    end
  end

  assign bus.txt_addr   = r_txtAddr;
  assign bus.rom_addr   = {bus.txt_data, 4'(r_side1.gRow)};
  assign bus.rgb        = r_rgb;
  assign bus.hsync_out  = r_hsOut;
  assign bus.vsync_out  = r_vsOut;
  assign bus.active_out = r_actOut;
endmodule

// File: tb/tb_char_render.sv
// Randomized bench for char_render: a cycle-indexed stimulus history feeds a
// behavioural model (cell arithmetic, glyph lookup, edge-counted blink phase).
module tb_char_render;
  localparam int          CHAR_W = 8;
  localparam int          CHAR_H = 16;
  localparam int          COLS   = 80;
  localparam int          ROWS   = 30;
  localparam int          BF     = 2;
  localparam logic [11:0] FG     = 12'hFFF;
  localparam logic [11:0] BG     = 12'h000;
  localparam int          HIST   = 8192;

  typedef struct {
    int hc;
    int vc;
    bit hs;
    bit vs;
    bit act;
    bit cen;
    int ccol;
    int crow;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  char_render_if #(.CHAR_W(CHAR_W)) bus ();

  char_render #(
    .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .COLS(COLS), .ROWS(ROWS),
    .BLINK_FRAMES(BF), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .pix_clk(clk),
    .rst    (rst),
    .bus    (bus)
  );

  logic [7:0] ram [0:4095];
  logic [7:0] rom [0:4095];

  always @(posedge clk) begin
    bus.txt_data <= ram[bus.txt_addr];
    bus.rom_data <= rom[bus.rom_addr];
  end

  stim_t       hist    [0:HIST-1];
  int          cumEdge [0:HIST-1];
  logic [11:0] pinRgb  [int];
  logic [11:0] pinTxt  [int];
  logic [11:0] pinRom  [int];
  int          cyc    = 0;
  int          base   = 0;
  int          checks = 0;
  int          errors = 0;
  int          edges  = 0;
  bit          prevVs = 1'b0;
  stim_t       idle   = '{hc: 0, vc: 0, hs: 0, vs: 0, act: 0, cen: 0, ccol: 0, crow: 0};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: observed %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int cellAddr(stim_t s);
    if (!s.act) return 0;
    return ((s.vc / CHAR_H) * COLS + s.hc / CHAR_W) % 4096;
  endfunction

  function automatic logic [11:0] modelRgb(stim_t s, bit phase);
    int         col;
    int         row;
    logic [7:0] glyph;
    bit         pix;
    bit         hit;
    if (!s.act) return 12'h000;
    col   = s.hc / CHAR_W;
    row   = s.vc / CHAR_H;
    glyph = rom[ram[cellAddr(s)] * CHAR_H + s.vc % CHAR_H];
    pix   = glyph[CHAR_W - 1 - s.hc % CHAR_W];
    hit   = s.cen && col == s.ccol && row == s.crow && col < COLS && row < ROWS;
    return (pix ^ (hit && phase)) ? FG : BG;
  endfunction

  task automatic checkCycle();
    int    t;
    stim_t s;
    bit    phase;
    t = cyc;
    if (t - 4 >= base) begin
      s     = hist[t-4];
      phase = ((cumEdge[t-2] / BF) % 2) == 0;
      checkOutput("rgb", bus.rgb, modelRgb(s, phase));
      checkOutput("hsync_out", bus.hsync_out, s.hs);
      checkOutput("vsync_out", bus.vsync_out, s.vs);
      checkOutput("active_out", bus.active_out, s.act);
    end else begin
      checkOutput("rgb_flush", bus.rgb, 0);
      checkOutput("active_flush", bus.active_out, 0);
    end
    if (t - 1 >= base) checkOutput("txt_addr", bus.txt_addr, cellAddr(hist[t-1]));
    else               checkOutput("txt_addr_flush", bus.txt_addr, 0);
    if (t - 2 >= base)
      checkOutput("rom_addr", bus.rom_addr,
                  ram[cellAddr(hist[t-2])] * CHAR_H + hist[t-2].vc % CHAR_H);
    if (pinRgb.exists(t)) checkOutput("pin_rgb", bus.rgb, pinRgb[t]);
    if (pinTxt.exists(t)) checkOutput("pin_txt_addr", bus.txt_addr, pinTxt[t]);
    if (pinRom.exists(t)) checkOutput("pin_rom_addr", bus.rom_addr, pinRom[t]);
  endtask

  task automatic drive(input stim_t s);
    bus.H_count    = 12'(s.hc);
    bus.V_count    = 12'(s.vc);
    bus.hsync      = s.hs;
    bus.vsync      = s.vs;
    bus.vid_active = s.act;
    bus.cursor_en  = s.cen;
    bus.cursor_col = 7'(s.ccol);
    bus.cursor_row = 5'(s.crow);
    hist[cyc]      = s;
    if (s.vs && !prevVs) edges++;
    cumEdge[cyc]   = edges;
    prevVs         = s.vs;
  endtask

  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= HIST - 1) begin
      $display("[TB] FAIL history_bound: cycle %0d exceeds %0d", cyc, HIST - 1);
      $fatal(1, "[TB] history overflow");
    end
    if (rst) checkCycle();
    drive(s);
  endtask

  task automatic resetSequence();
    rst = 1'b0;
    #1;
    checkOutput("reset_rgb", bus.rgb, 0);
    checkOutput("reset_txt_addr", bus.txt_addr, 0);
    checkOutput("reset_hsync_out", bus.hsync_out, 0);
    checkOutput("reset_vsync_out", bus.vsync_out, 0);
    checkOutput("reset_active_out", bus.active_out, 0);
    checkOutput("reset_rom_row", bus.rom_addr[3:0], 0);
    repeat (3) applyStimulus(idle);
    rst    = 1'b1;
    base   = cyc;
    prevVs = 1'b0;
    edges  = 0;
    drive(idle);
  endtask

  function automatic stim_t randStim(int ccol, int crow);
    stim_t s;
    if ($urandom_range(0, 1) == 0) begin
      s.hc = ccol * CHAR_W + $urandom_range(0, CHAR_W - 1);
      s.vc = crow * CHAR_H + $urandom_range(0, CHAR_H - 1);
    end else begin
      s.hc = $urandom_range(0, 1023);
      s.vc = $urandom_range(0, 600);
    end
    s.hs   = 1'($urandom_range(0, 1));
    s.vs   = 1'($urandom_range(0, 1));
    s.act  = $urandom_range(0, 4) != 0;
    s.cen  = $urandom_range(0, 7) != 0;
    s.ccol = ccol;
    s.crow = crow;
    return s;
  endfunction

  task automatic runRandom(input int n);
    int ccol;
    int crow;
    ccol = 0;
    crow = 0;
    for (int i = 0; i < n; i++) begin
      if (i % 64 == 0) begin
        ccol = $urandom_range(0, 90);
        crow = $urandom_range(0, 33);
      end
      applyStimulus(randStim(ccol, crow));
    end
  endtask

  initial begin
    logic [11:0] latRgb [8];
    bit          blinkTable [6];
    stim_t       s;
    latRgb     = '{FG, BG, BG, BG, BG, BG, BG, FG};
    blinkTable = '{1, 0, 0, 1, 1, 0};

    for (int i = 0; i < 4096; i++) begin
      ram[i] = 8'($urandom);
      rom[i] = 8'($urandom);
    end
    ram[0]       = 8'h41;
    rom[12'h410] = 8'b1000_0001;
    ram[2399]    = 8'h5A;
    rom[12'h5AF] = 8'h01;
    for (int i = 0; i < CHAR_H; i++) rom[12'h200 + i] = 8'h00;
    for (int c = 4; c <= 6; c++) ram[2 * COLS + c] = 8'h20;
    ram[1 * COLS + 5] = 8'h20;
    ram[3 * COLS + 5] = 8'h20;

    $display("[TB] char_render bench starting");
    drive(idle);
    #2;
    resetSequence();

    // First glyph row of RAM[0]: both edge pixels lit.
    for (int h = 0; h < 8; h++) begin
      s     = idle;
      s.hc  = h;
      s.act = 1'b1;
      applyStimulus(s);
      if (h == 0) begin
        pinTxt[cyc + 1] = 12'd0;
        pinRom[cyc + 2] = 12'h410;
      end
      pinRgb[cyc + 4] = latRgb[h];
    end
    repeat (6) applyStimulus(idle);

    // Bottom-right pixel of the text area.
    s     = idle;
    s.hc  = 639;
    s.vc  = 479;
    s.act = 1'b1;
    applyStimulus(s);
    pinTxt[cyc + 1] = 12'd2399;
    pinRom[cyc + 2] = 12'h5AF;
    pinRgb[cyc + 4] = FG;
    repeat (6) applyStimulus(idle);

    // Blanking pixel.
    s    = idle;
    s.hc = 640;
    s.vc = 100;
    s.hs = 1'b1;
    applyStimulus(s);
    pinTxt[cyc + 1] = 12'd0;
    pinRgb[cyc + 4] = 12'h000;
    repeat (6) applyStimulus(idle);

    // Cursor blink across six short frames.
    for (int f = 0; f < 6; f++) begin
      s      = idle;
      s.cen  = 1'b1;
      s.ccol = 5;
      s.crow = 2;
      s.vs   = 1'b1;
      repeat (2) applyStimulus(s);
      s.vs   = 1'b0;
      repeat (4) applyStimulus(s);
      for (int h = 32; h < 56; h++) begin
        s.hc  = h;
        s.vc  = 34;
        s.act = 1'b1;
        applyStimulus(s);
        pinRgb[cyc + 4] = (h >= 40 && h < 48 && blinkTable[f]) ? FG : BG;
      end
      s.act = 1'b0;
      repeat (4) applyStimulus(s);
    end

    runRandom(3000);
    resetSequence();
    runRandom(400);
    repeat (6) applyStimulus(idle);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
